// File: rtl/fifo_write_arbiter_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write arbiter.
// Holds the FSM state enum, counter width and index-width helper.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    localparam int CNT_WIDTH = 8;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: requester bundle plus FIFO write port.
// master = arbiter side, slave = requesters/FIFO side.
interface fifo_write_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int IW = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          Full;
    logic                          wr_en;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic [IW-1:0]                 grant_id;
    logic                          busy;

    modport master (
        input  req_valid, req_data, req_last, Full,
        output req_ready, wr_en, wr_data, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, req_last, Full,
        input  req_ready, wr_en, wr_data, grant_id, busy
    );

endinterface

// File: rtl/fifo_write_arbiter_rr_picker.sv
// rr_picker: rotating-priority search starting at ptr_i+1 (mod N).
// Ports: req_i request vector, ptr_i last winner, found_o/idx_o result.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    // Scan farthest-to-nearest so the nearest set bit overwrites last.
    always_comb begin
        logic [IW:0] c;
        found_o = 1'b0;
        idx_o   = '0;
        c       = '0;
        for (int k = N; k >= 1; k--) begin
            c = {1'b0, ptr_i} + (IW+1)'(k);
            if (c >= (IW+1)'(N)) begin
                c = c - (IW+1)'(N);
            end
            if (req_i[c[IW-1:0]]) begin
                found_o = 1'b1;
                idx_o   = c[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter for the FIFO write port.
// Ports: write_clk, rst_n (async low), bus (master modport: req_*, Full, wr_*, grant_id, busy).
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 8,
    parameter int STALL_MAX  = 4
) (
    input  logic                 write_clk,
    input  logic                 rst_n,
    fifo_write_arbiter_if.master bus
);

    localparam int IW = idx_width(NUM_REQ);

    state_e               state_q;
    logic [IW-1:0]        rr_ptr_q;
    logic [IW-1:0]        grant_q;
    logic [CNT_WIDTH-1:0] beat_q;
    logic [CNT_WIDTH-1:0] stall_q;

    logic                  found;
    logic [IW-1:0]         pick;
    logic                  active;
    logic                  valid_g;
    logic                  last_g;
    logic                  xfer;
    logic                  term;
    logic [DATA_WIDTH-1:0] slice [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign slice[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req_i   (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .found_o (found),
        .idx_o   (pick)
    );

    assign active  = (state_q == BURST);
    assign valid_g = bus.req_valid[grant_q];
    assign last_g  = bus.req_last[grant_q];
    assign xfer    = active & valid_g & ~bus.Full;

    // Full with valid held is backpressure: neither stall nor end.
    assign term = (xfer & last_g)
                | (xfer & (beat_q == CNT_WIDTH'(MAX_BURST - 1)))
                | (active & ~valid_g
                   & (stall_q == CNT_WIDTH'(STALL_MAX - 1)));

    assign bus.wr_en     = xfer;
    assign bus.req_ready = xfer ? (NUM_REQ'(1) << grant_q) : '0;
    assign bus.wr_data   = active ? slice[grant_q] : '0;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = active;

    always_ff @(posedge write_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= IW'(NUM_REQ - 1);
            grant_q  <= '0;
            beat_q   <= '0;
            stall_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_q <= pick;
                        beat_q  <= '0;
                        stall_q <= '0;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (xfer) begin
                        beat_q <= beat_q + 1'b1;
                    end
                    if (valid_g) begin
                        stall_q <= '0;
                    end else begin
                        stall_q <= stall_q + 1'b1;
                    end
                    if (term) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= grant_q;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed checks of the FIFO write arbiter.
// Covers reset, single burst, round-robin, burst cap, Full, stall, async reset.
module tb_fifo_write_arbiter;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    fifo_write_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

    fifo_write_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (8),
        .STALL_MAX  (4)
    ) dut (
        .write_clk (clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic en,
                           input logic [1:0] gid, input logic [7:0] d,
                           input logic [3:0] rdy, input logic b);
        chk({tag, ".wr_en"},     32'(bus.wr_en),     32'(en));
        chk({tag, ".grant_id"},  32'(bus.grant_id),  32'(gid));
        chk({tag, ".wr_data"},   32'(bus.wr_data),   32'(d));
        chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'(rdy));
        chk({tag, ".busy"},      32'(bus.busy),      32'(b));
    endtask

    // Inputs are set by the caller just after an edge; check, then advance.
    task automatic beat(input string tag, input logic en,
                        input logic [1:0] gid, input logic [7:0] d,
                        input logic [3:0] rdy, input logic b);
        #1;
        chk_all(tag, en, gid, d, rdy, b);
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [7:0] v);
        bus.req_data[i*8 +: 8] = v;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.Full      = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;

        // Reset values
        do_reset();
        rst_n = 1'b0;
        #1;
        chk_all("reset", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single requester, 4-word packet
        bus.req_valid = 4'b0001;
        set_word(0, 8'hA0);
        beat("s1.idle", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        for (int w = 0; w < 4; w++) begin
            set_word(0, 8'(8'hA0 + w));
            bus.req_last = (w == 3) ? 4'b0001 : 4'b0000;
            beat("s1.wr", 1'b1, 2'd0, 8'(8'hA0 + w), 4'b0001, 1'b1);
        end
        bus.req_valid = '0;
        bus.req_last  = '0;
        beat("s1.done", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);

        // Round-robin, single-word packets
        do_reset();
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        for (int i = 0; i < 4; i++) set_word(i, 8'(8'h10 + i));
        for (int k = 0; k < 5; k++) begin
            beat("rr.idle", 1'b0, 2'((k == 0) ? 0 : (k - 1) % 4),
                 8'h00, 4'b0000, 1'b0);
            beat("rr.wr", 1'b1, 2'(k % 4), 8'(8'h10 + k % 4),
                 4'(1 << (k % 4)), 1'b1);
        end
        bus.req_valid = '0;
        bus.req_last  = '0;

        // Burst cap: req 2 streams 20 words, req 1 one word
        do_reset();
        bus.req_valid = 4'b0100;
        set_word(2, 8'h40);
        beat("cap.idle0", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        bus.req_valid = 4'b0110;
        bus.req_last  = 4'b0010;
        set_word(1, 8'h91);
        for (int n = 0; n < 8; n++) begin
            set_word(2, 8'(8'h40 + n));
            beat("cap.b1", 1'b1, 2'd2, 8'(8'h40 + n), 4'b0100, 1'b1);
        end
        set_word(2, 8'h48);
        beat("cap.idle1", 1'b0, 2'd2, 8'h00, 4'b0000, 1'b0);
        beat("cap.r1", 1'b1, 2'd1, 8'h91, 4'b0010, 1'b1);
        bus.req_valid = 4'b0100;
        bus.req_last  = 4'b0000;
        beat("cap.idle2", 1'b0, 2'd1, 8'h00, 4'b0000, 1'b0);
        for (int n = 8; n < 16; n++) begin
            set_word(2, 8'(8'h40 + n));
            beat("cap.b2", 1'b1, 2'd2, 8'(8'h40 + n), 4'b0100, 1'b1);
        end
        set_word(2, 8'h50);
        beat("cap.idle3", 1'b0, 2'd2, 8'h00, 4'b0000, 1'b0);
        for (int n = 16; n < 20; n++) begin
            set_word(2, 8'(8'h40 + n));
            beat("cap.b3", 1'b1, 2'd2, 8'(8'h40 + n), 4'b0100, 1'b1);
        end
        bus.req_valid = 4'b0000;
        for (int s = 0; s < 4; s++) begin
            beat("cap.stall", 1'b0, 2'd2, 8'h53, 4'b0000, 1'b1);
        end
        beat("cap.end", 1'b0, 2'd2, 8'h00, 4'b0000, 1'b0);

        // Full backpressure for 10 cycles mid-burst
        do_reset();
        bus.req_valid = 4'b0001;
        set_word(0, 8'h60);
        beat("full.idle", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        beat("full.w0", 1'b1, 2'd0, 8'h60, 4'b0001, 1'b1);
        set_word(0, 8'h61);
        beat("full.w1", 1'b1, 2'd0, 8'h61, 4'b0001, 1'b1);
        set_word(0, 8'h62);
        bus.Full = 1'b1;
        for (int f = 0; f < 10; f++) begin
            beat("full.hold", 1'b0, 2'd0, 8'h62, 4'b0000, 1'b1);
        end
        bus.Full     = 1'b0;
        bus.req_last = 4'b0001;
        beat("full.resume", 1'b1, 2'd0, 8'h62, 4'b0001, 1'b1);
        bus.req_valid = '0;
        bus.req_last  = '0;
        beat("full.end", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);

        // Stall timeout on requester 3, then requester 0
        do_reset();
        bus.req_valid = 4'b1000;
        set_word(3, 8'h73);
        beat("stl.idle", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        beat("stl.w", 1'b1, 2'd3, 8'h73, 4'b1000, 1'b1);
        set_word(3, 8'h74);
        set_word(0, 8'h80);
        bus.req_valid = 4'b0001;
        bus.req_last  = 4'b0001;
        for (int s = 0; s < 4; s++) begin
            beat("stl.hold", 1'b0, 2'd3, 8'h74, 4'b0000, 1'b1);
        end
        beat("stl.idle2", 1'b0, 2'd3, 8'h00, 4'b0000, 1'b0);
        beat("stl.r0", 1'b1, 2'd0, 8'h80, 4'b0001, 1'b1);
        bus.req_valid = '0;
        bus.req_last  = '0;
        beat("stl.end", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);

        // Asynchronous reset during an active write
        do_reset();
        bus.req_valid = 4'b0011;
        set_word(0, 8'hE0);
        set_word(1, 8'hE1);
        beat("rst.idle", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        #1;
        chk_all("rst.pre", 1'b1, 2'd0, 8'hE0, 4'b0001, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all("rst.async", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        beat("rst.idle2", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        beat("rst.r0", 1'b1, 2'd0, 8'hE0, 4'b0001, 1'b1);
        bus.req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of the asynchronous FIFO among NUM_REQ requesters in the write_clk domain.
- Grants one requester at a time, round-robin. Each grant lasts a bounded burst, then passes on.
- Gates every write with the FIFO Full flag, so the FIFO never sees a write while full.
- Sits between the producer blocks and the FIFO write port (wr_en / wr_data / Full).

Parameters:
- NUM_REQ, 4: number of requesters, range 2..16.
- DATA_WIDTH, 8: FIFO word width.
- MAX_BURST, 8: maximum beats per grant, range 1..255.
- STALL_MAX, 4: consecutive cycles the granted requester may hold req_valid low before the grant is revoked, range 1..255.

Ports:
- write_clk  in  1  FIFO write-domain clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester word; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  per-requester: current word ends its packet.
- req_ready  out  NUM_REQ  per-requester: word accepted this cycle.
- Full  in  1  FIFO full flag, write domain.
- wr_en  out  1  FIFO write enable.
- wr_data  out  DATA_WIDTH  FIFO write data.
- grant_id  out  clog2(NUM_REQ)  current or last granted requester.
- busy  out  1  a grant is active.

Behaviour:
- Reset values (asynchronous, on rst_n low):
  - state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 wins first), grant_id=0, beat_cnt=0, stall_cnt=0.
  - Outputs: req_ready=0, wr_en=0, busy=0, wr_data=0.
  - Reset mid-burst drops wr_en and req_ready immediately, with no partial-cycle write.
- States: IDLE, BURST.
- IDLE:
  - If any req_valid is high, select the first set index searching rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ).
  - Register grant_id, clear beat_cnt and stall_cnt, go to BURST.
  - No transfer happens in IDLE. Arbitration latency is 1 cycle from req_valid to the first possible write.
- BURST, with g = grant_id:
  - Transfer condition: xfer = req_valid[g] & ~Full.
  - wr_en = xfer; req_ready[g] = xfer; all other req_ready bits are 0; wr_data = req_data slice g.
  - These outputs are combinational from registered state plus the inputs. There is no extra latency.
  - wr_en must never be high while Full is high.
  - wr_data is don't-care when wr_en=0, but must be held as the g slice (no X).
- Burst termination: return to IDLE, rr_ptr<=g, at the clock edge where any of these holds:
  - (a) xfer & req_last[g];
  - (b) xfer & beat_cnt==MAX_BURST-1;
  - (c) stall_cnt==STALL_MAX-1 & ~req_valid[g].
- Counters:
  - beat_cnt increments on each xfer.
  - stall_cnt increments when req_valid[g] is low and clears when req_valid[g] is high.
  - Cycles where req_valid[g]=1 and Full=1 are backpressure. They do not count as stall and do not terminate the grant.
- busy=1 exactly in BURST.
- Packets are not atomic across MAX_BURST. A packet longer than MAX_BURST continues in a later grant and may interleave with other requesters in the FIFO.
- Back-to-back grants: after termination there is one IDLE cycle, then the next requester (round-robin from g+1) is granted.
- A single continuously requesting source re-wins after its own termination if no other requester is valid.
- Requester valid/data must stay stable until req_ready (standard valid/ready). The arbiter does not check this.
- Widths: beat_cnt and stall_cnt are 8 bits. grant_id index math is modulo NUM_REQ, with NUM_REQ not restricted to a power of two.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum {IDLE, BURST};
  - CNT_WIDTH=8;
  - a clog2-based index-width function.
- One combinational sub-module, rr_picker (inputs: req vector, rr_ptr; outputs: found, index).
  - Implements the rotating priority search.
  - Reused later for the read-side scheduler.
- Counters and FSM live in fifo_write_arbiter.

Test Plan:
- Reset then single requester: req_valid=0001, words 0xA0..0xA3 with req_last on 0xA3 → wr_en low in the first cycle, then 4 consecutive writes 0xA0..0xA3, back to IDLE, busy falls.
- Round-robin: all four valid continuously, req_last every word → grants in order 0,1,2,3,0. Each grant is 1 write followed by 1 IDLE cycle.
- Burst cap: requester 2 streams 20 words, no req_last, MAX_BURST=8, requester 1 also valid → 8 writes from 2, then 1, then the remaining words of 2 in later grants.
- Full backpressure: during a burst, hold Full=1 for 10 cycles with req_valid held → wr_en=0 and req_ready=0 throughout, grant retained, no stall termination. Writes resume the cycle after Full falls.
- Stall timeout: granted requester 3 drops req_valid for 4 cycles (STALL_MAX=4) → grant revoked at the 4th cycle, requester 0 is granted next. No write occurs during the stall.
- Reset mid-burst: assert rst_n low during an active write → wr_en, req_ready and busy go 0 asynchronously. After release, requester 0 has first priority.
